round_ctrl: RTL

- Game-flow controller that drives the duck sprite block.
- Produces the duck `state` code, the `new_round` pulse and the `shot` request.
- Consumes the duck block's `bird_shot`, `flew_away` and `duck_ded_done` status, plus the trigger input and crosshair position.
- Tracks ammo, ducks per round, hits, round number and score, and feeds these to the HUD/text renderer.

---
 rtl/round_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/round_ctrl.sv
// Game-flow controller for the duck-hunt round: sequences title, flight, fall,
// escape and game-over, and keeps ammo, hit, round and score bookkeeping for the HUD.
module round_ctrl #(
    parameter int DUCKS_PER_ROUND = 10,
    parameter int HITS_TO_PASS    = 6,
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int DUCK_SIZE       = 64,
    parameter int ESCAPE_FRAMES   = 60,
    parameter int HIT_POINTS      = 500
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start_btn,
    input  logic        trigger,
    input  logic [9:0]  cross_x,
    input  logic [9:0]  cross_y,
    input  logic [9:0]  duck_x,
    input  logic [9:0]  duck_y,
    input  logic        bird_shot,
    input  logic        flew_away,
    input  logic        duck_ded_done,
    output logic [2:0]  state,
    output logic        shot,
    output logic        new_round,
    output logic [1:0]  shots_left,
    output logic [3:0]  duck_num,
    output logic [3:0]  ducks_hit,
    output logic [7:0]  round,
    output logic [15:0] score
);

    localparam int ESC_W = $clog2(ESCAPE_FRAMES + 1);

    typedef enum logic [2:0] {
        S_TITLE,
        S_START,
        S_FLY,
        S_FALL,
        S_ESCAPE,
        S_NEXT,
        S_GAMEOVER
    } fsm_t;

    fsm_t fsm, fsm_d;

    logic             frame_q1, frame_q2;
    logic             trig_s1, trig_s2, trig_s3;
    logic             fe, te;
    logic             in_box;
    logic [9:0]       diff_x, diff_y;
    logic [16:0]      score_sum;
    logic [ESC_W-1:0] esc_cnt, esc_d;

    logic [2:0]  state_d;
    logic        shot_d, new_round_d;
    logic [1:0]  shots_d;
    logic [3:0]  duck_d, hits_d;
    logic [7:0]  round_d;
    logic [15:0] score_d;

    assign fe = frame_q1 & ~frame_q2;
    assign te = trig_s2 & ~trig_s3;

    // Unsigned 10-bit differences: a crosshair left of / above the duck wraps large and misses.
    assign diff_x    = cross_x - duck_x;
    assign diff_y    = cross_y - duck_y;
    assign in_box    = (diff_x < 10'(DUCK_SIZE)) && (diff_y < 10'(DUCK_SIZE));
    assign score_sum = {1'b0, score} + 17'(HIT_POINTS);

    always_comb begin
        fsm_d       = fsm;
        shot_d      = shot;
        new_round_d = new_round;
        shots_d     = shots_left;
        duck_d      = duck_num;
        hits_d      = ducks_hit;
        round_d     = round;
        score_d     = score;
        esc_d       = esc_cnt;
        state_d     = 3'b000;

        case (fsm)
            S_TITLE: begin
                shot_d      = 1'b0;
                new_round_d = 1'b0;
                if (start_btn) begin
                    fsm_d       = S_START;
                    new_round_d = 1'b1;
                    shots_d     = 2'(SHOTS_PER_DUCK);
                end
            end
            S_START: begin
                if (fe) begin
                    fsm_d       = S_FLY;
                    new_round_d = 1'b0;
                end
            end
            S_FLY: begin
                // An escape overrides a simultaneous hit report.
                if (flew_away) begin
                    fsm_d  = S_ESCAPE;
                    shot_d = 1'b0;
                    esc_d  = '0;
                end else if (bird_shot) begin
                    fsm_d   = S_FALL;
                    shot_d  = 1'b0;
                    hits_d  = ducks_hit + 4'd1;
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end else if (te && (shots_left != 2'd0) && !shot) begin
                    shots_d = shots_left - 2'd1;
                    if (in_box) begin
                        shot_d = 1'b1;
                    end
                end
            end
            S_FALL: begin
                if (duck_ded_done) begin
                    fsm_d = S_NEXT;
                end
            end
            S_ESCAPE: begin
                if (fe) begin
                    if (esc_cnt == ESC_W'(ESCAPE_FRAMES - 1)) begin
                        fsm_d = S_NEXT;
                    end else begin
                        esc_d = esc_cnt + 1'b1;
                    end
                end
            end
            S_NEXT: begin
                if (duck_num < 4'(DUCKS_PER_ROUND - 1)) begin
                    fsm_d       = S_START;
                    duck_d      = duck_num + 4'd1;
                    new_round_d = 1'b0;
                    shots_d     = 2'(SHOTS_PER_DUCK);
                    shot_d      = 1'b0;
                end else if (ducks_hit >= 4'(HITS_TO_PASS)) begin
                    fsm_d       = S_START;
                    round_d     = (round == 8'hFF) ? round : round + 8'd1;
                    duck_d      = 4'd0;
                    hits_d      = 4'd0;
                    new_round_d = 1'b1;
                    shots_d     = 2'(SHOTS_PER_DUCK);
                    shot_d      = 1'b0;
                end else begin
                    fsm_d = S_GAMEOVER;
                end
            end
            S_GAMEOVER: begin
                if (start_btn) begin
                    fsm_d   = S_TITLE;
                    score_d = 16'd0;
                    round_d = 8'd1;
                    duck_d  = 4'd0;
                    hits_d  = 4'd0;
                end
            end
            default: begin
                fsm_d = S_TITLE;
            end
        endcase

        // ESCAPE and NEXT share a code so the duck block sees one continuous escape.
        case (fsm_d)
            S_TITLE:    state_d = 3'b000;
            S_START:    state_d = 3'b001;
            S_FLY:      state_d = 3'b010;
            S_ESCAPE:   state_d = 3'b011;
            S_NEXT:     state_d = 3'b011;
            S_FALL:     state_d = 3'b100;
            S_GAMEOVER: state_d = 3'b101;
            default:    state_d = 3'b000;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fsm        <= S_TITLE;
            state      <= 3'b000;
            shot       <= 1'b0;
            new_round  <= 1'b0;
            shots_left <= 2'(SHOTS_PER_DUCK);
            duck_num   <= 4'd0;
            ducks_hit  <= 4'd0;
            round      <= 8'd1;
            score      <= 16'd0;
            esc_cnt    <= '0;
            frame_q1   <= 1'b0;
            frame_q2   <= 1'b0;
            trig_s1    <= 1'b0;
            trig_s2    <= 1'b0;
            trig_s3    <= 1'b0;
        end else begin
            fsm        <= fsm_d;
            state      <= state_d;
            shot       <= shot_d;
            new_round  <= new_round_d;
            shots_left <= shots_d;
            duck_num   <= duck_d;
            ducks_hit  <= hits_d;
            round      <= round_d;
            score      <= score_d;
            esc_cnt    <= esc_d;
            frame_q1   <= frame_clk;
            frame_q2   <= frame_q1;
            trig_s1    <= trigger;
            trig_s2    <= trig_s1;
            trig_s3    <= trig_s2;
        end
    end

endmodule
